tweet_ram_sched: RTL and testbench
==================================

# tweet_ram_sched

Scheduler and owner of the tweetboard's single-port 256x16 character RAM. It shares the RAM between three requesters: an internal clear sweep, the serial-receive writer (append or backspace), and the playback reader that feeds the serial transmitter. It also keeps the stored-message length, enforces the 160-character limit, and is the only block that drives the RAM's address, write-enable and write-data pins.

## Interface
- ADDR_W, 8, RAM address width (depth 2^ADDR_W)
- MAX_LEN, 160, maximum stored characters
- BKSP, 8'h08, character code treated as backspace
- sysclk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- clr_req  in  1  single-cycle pulse; requests a full RAM clear
- clr_busy  out  1  high while the clear sweep runs
- wr_req  in  1  write request; held high until wr_ack
- wr_data  in  8  received character; BKSP means delete last character
- wr_ack  out  1  one-cycle pulse when the write request is completed
- wr_drop  out  1  valid with wr_ack; request had no effect (full append, or empty backspace)
- rd_req  in  1  read-next request; held high until rd_valid or rd_done
- rd_rewind  in  1  single-cycle pulse; sets the read pointer to 0
- rd_valid  out  1  one-cycle pulse; rd_data holds the next character
- rd_done  out  1  one-cycle pulse; no more characters (request completed without data)
- rd_data  out  8  character from the last successful read
- len  out  ADDR_W  current stored length
- full  out  1  len == MAX_LEN
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  16  RAM write data: bit15 = valid, [7:0] = character, [14:8] = 0
- ram_rdata  in  16  RAM read data, synchronous, valid one cycle after ram_addr

## Operation
- States: CLEAR, IDLE, WRITE, RD_ADDR, RD_WAIT.
- Priority in IDLE: clr_req, then wr_req, then rd_req. Losing requests stay pending; they are not dropped.
- **CLEAR**
  - ram_we=1 and ram_wdata=0 every cycle.
  - Sweep counter runs 0..2^ADDR_W-1, one address per cycle.
  - After address 255 the block goes to IDLE with len=0 and rd_ptr=0.
  - clr_req, wr_req and rd_req are ignored (left pending) during CLEAR.
- **WRITE, append** (wr_data != BKSP)
  - If len < MAX_LEN: write {1'b1,7'b0,wr_data} at address len, then len <= len+1.
  - Otherwise: no RAM write, wr_drop=1.
- **WRITE, backspace** (wr_data == BKSP)
  - If len > 0: write 0 at address len-1, then len <= len-1.
  - Otherwise: no RAM write, wr_drop=1.
  - If rd_ptr > new len, rd_ptr is clamped to the new len.
- **Read**
  - If rd_ptr >= len in IDLE: go straight to done; no RAM access.
  - Otherwise RD_ADDR drives ram_addr=rd_ptr, then RD_WAIT samples ram_rdata.
  - If bit15 of the sample is 1: rd_data <= [7:0], rd_valid, rd_ptr <= rd_ptr+1.
  - If bit15 is 0: rd_done, rd_ptr unchanged.
- rd_rewind is accepted in any state except RD_ADDR/RD_WAIT. If it arrives during a read, it is applied when the read completes.
- rd_rewind together with rd_req in IDLE: the rewind is applied first, so the read fetches address 0.
- Outside the CLEAR and WRITE cycles: ram_we=0, and ram_addr holds its last value.

## Timing
- Reset values:
  - state=CLEAR, sweep=0, so clr_busy=1 and ram_we=1 immediately after reset.
  - wr_ack=0, wr_drop=0, rd_valid=0, rd_done=0, rd_data=0.
  - len=0, full=0, rd_ptr=0, ram_addr=0, ram_wdata=0.
- Reset asserted mid-operation aborts it immediately. Pending acks are lost, and the sweep restarts from address 0 after reset is released.
- Clear: clr_req sampled at edge N. clr_busy is high from cycle N+1 through N+256 and low at N+257; total 256 write cycles.
- Write: wr_req sampled in IDLE at edge N.
  - WRITE state occupies cycle N+1; ram_we and wr_ack are both high in N+1.
  - len updates at edge N+2.
  - Back-to-back writes are possible every 2 cycles.
- Read: rd_req sampled in IDLE at edge N.
  - ram_addr=rd_ptr during N+1; ram_rdata is valid during N+2.
  - rd_valid or rd_done is high during N+3, and the block is back in IDLE at N+3.
  - Fast-path done (rd_ptr >= len): rd_done is high during N+1.
- Requesters must drop req in the cycle after the ack, or keep it high to request again.
- Outputs wr_ack, wr_drop, rd_valid and rd_done are registered and exactly one cycle wide.

## Test plan
- Reset release: clr_busy=1 for 256 cycles, ram_we=1 with ram_wdata=0 at addresses 0..255, then len=0.
- Append 'H','i' (8'h48, 8'h69) -> RAM[0]=16'h8048, RAM[1]=16'h8069, len=2, each wr_ack one cycle after request with wr_drop=0.
- Backspace with len=2 -> RAM[1]=0, len=1. Three further backspaces -> one write, then two acks with wr_drop=1 and len staying 0.
- Append 161 characters -> len=160 and full=1; the 161st gets wr_drop=1 and ram_we stays 0.
- Store "AB", rd_rewind, then three rd_req -> rd_valid with 8'h41, then rd_valid with 8'h42, then rd_done. rd_valid is 3 cycles after each sampled request.
- Assert wr_req and rd_req in the same cycle that clr_req is sampled -> clear runs first, then the write is acked, then the read. Asserting reset mid-sweep restarts the sweep at address 0.

Source files
------------

// File: rtl/tweet_ram_sched.sv
// rtl/tweet_ram_sched.sv - scheduler and sole owner of the 256x16 tweetboard character RAM
module tweet_ram_sched #(
    parameter int          ADDR_W  = 8,
    parameter int          MAX_LEN = 160,
    parameter logic [7:0]  BKSP    = 8'h08
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              wr_req,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic              wr_drop,
    input  logic              rd_req,
    input  logic              rd_rewind,
    output logic              rd_valid,
    output logic              rd_done,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] len,
    output logic              full,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(MAX_LEN);
    localparam logic [ADDR_W-1:0] LAST  = '1;
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;      // doubles as the clear sweep counter
    logic [15:0]       wdata_q,    wdata_d;
    logic [ADDR_W-1:0] len_q,      len_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [7:0]        rd_data_q,  rd_data_d;
    logic              wr_ack_q,   wr_ack_d;
    logic              wr_drop_q,  wr_drop_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_done_q,  rd_done_d;
    logic              bksp_q,     bksp_d;
    logic              clr_pend_q, clr_pend_d;  // clear pulse that arrived while busy
    logic              rew_pend_q, rew_pend_d;  // rewind pulse that arrived mid-read

    logic              rew_now;
    logic [ADDR_W-1:0] ptr_eff;
    logic [ADDR_W-1:0] new_len;
    logic              in_read;
    logic              unused_rdata;

    assign unused_rdata = ^ram_rdata[14:8];

    // State register and all datapath flops
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_CLEAR;
            addr_q     <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            wr_ack_q   <= 1'b0;
            wr_drop_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            bksp_q     <= 1'b0;
            clr_pend_q <= 1'b0;
            rew_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            wr_ack_q   <= wr_ack_d;
            wr_drop_q  <= wr_drop_d;
            rd_valid_q <= rd_valid_d;
            rd_done_q  <= rd_done_d;
            bksp_q     <= bksp_d;
            clr_pend_q <= clr_pend_d;
            rew_pend_q <= rew_pend_d;
        end
    end

    // Next-state, arbitration and RAM command generation
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        wr_ack_d   = 1'b0;
        wr_drop_d  = 1'b0;
        rd_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        bksp_d     = bksp_q;
        clr_pend_d = clr_pend_q | clr_req;
        rew_pend_d = rew_pend_q;
        new_len    = len_q;
        rew_now    = rew_pend_q | rd_rewind;
        ptr_eff    = rew_now ? '0 : rd_ptr_q;
        in_read    = (state_q == S_RD_ADDR) || (state_q == S_RD_WAIT);

        case (state_q)
            S_CLEAR: begin
                wdata_d = '0;
                if (addr_q == LAST) begin
                    state_d  = S_IDLE;
                    len_d    = '0;
                    rd_ptr_d = '0;
                end else begin
                    addr_d = addr_q + ONE;
                end
            end
            S_IDLE: begin
                if (clr_pend_q || clr_req) begin
                    state_d    = S_CLEAR;
                    addr_d     = '0;
                    wdata_d    = '0;
                    clr_pend_d = 1'b0;
                end else if (wr_req) begin
                    state_d  = S_WRITE;
                    wr_ack_d = 1'b1;
                    bksp_d   = (wr_data == BKSP);
                    if (wr_data == BKSP) begin
                        if (len_q != '0) begin
                            addr_d  = len_q - ONE;
                            wdata_d = '0;
                        end else begin
                            wr_drop_d = 1'b1;
                        end
                    end else begin
                        if (len_q < MAX_L) begin
                            addr_d  = len_q;
                            wdata_d = {1'b1, 7'b0, wr_data};
                        end else begin
                            wr_drop_d = 1'b1;
                        end
                    end
                end else if (rd_req && !rd_valid_q && !rd_done_q) begin
                    // the previous read's response is still visible while its
                    // requester is allowed to hold rd_req, so it is not re-taken
                    if (ptr_eff >= len_q) begin
                        rd_done_d = 1'b1;
                    end else begin
                        state_d = S_RD_ADDR;
                        addr_d  = ptr_eff;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (!wr_drop_q) begin
                    new_len = bksp_q ? (len_q - ONE) : (len_q + ONE);
                    len_d   = new_len;
                    if (bksp_q && (rd_ptr_q > new_len)) begin
                        rd_ptr_d = new_len;
                    end
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_d = S_IDLE;
                if (ram_rdata[15]) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = ram_rdata[7:0];
                    rd_ptr_d   = rd_ptr_q + ONE;
                end else begin
                    rd_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
                addr_d  = '0;
                wdata_d = '0;
            end
        endcase

        // rewind wins over any pointer update; mid-read it waits for completion
        if (!in_read || (state_q == S_RD_WAIT)) begin
            if (rew_now) begin
                rd_ptr_d   = '0;
                rew_pend_d = 1'b0;
            end
        end else begin
            rew_pend_d = rew_now;
        end
    end

    assign clr_busy  = (state_q == S_CLEAR);
    assign ram_we    = (state_q == S_CLEAR) || ((state_q == S_WRITE) && !wr_drop_q);
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign wr_ack    = wr_ack_q;
    assign wr_drop   = wr_drop_q;
    assign rd_valid  = rd_valid_q;
    assign rd_done   = rd_done_q;
    assign rd_data   = rd_data_q;
    assign len       = len_q;
    assign full      = (len_q == MAX_L);

endmodule

// File: tb/tb_tweet_ram_sched.sv
// tb/tb_tweet_ram_sched.sv - directed self-checking bench for tweet_ram_sched
module tb_tweet_ram_sched;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        clr_req;
    logic        clr_busy;
    logic        wr_req;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        wr_drop;
    logic        rd_req;
    logic        rd_rewind;
    logic        rd_valid;
    logic        rd_done;
    logic [7:0]  rd_data;
    logic [7:0]  len;
    logic        full;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [256];

    int n_chk  = 0;
    int n_pass = 0;

    tweet_ram_sched dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_drop   (wr_drop),
        .rd_req    (rd_req),
        .rd_rewind (rd_rewind),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .len       (len),
        .full      (full),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 sysclk = ~sysclk;

    // Synchronous single-port RAM, read-before-write
    always @(posedge sysclk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic sweep_check(input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (clr_busy && n < 600) begin
            if (!(ram_we && ram_wdata == 16'h0 && ram_addr == n[7:0])) bad++;
            n++;
            tick();
        end
        check({tag, "_cycles"}, n, 256);
        check({tag, "_writes"}, bad, 0);
        check({tag, "_len"}, len, 0);
    endtask

    task automatic wr(input logic [7:0] ch, input logic exp_drop, input logic [7:0] exp_len);
        wr_req = 1'b1;
        wr_data = ch;
        tick();
        check("wr_ack", wr_ack, 1);
        check("wr_drop", wr_drop, exp_drop);
        check("wr_we", ram_we, !exp_drop);
        wr_req = 1'b0;
        tick();
        check("wr_ack_off", wr_ack, 0);
        check("wr_len", len, exp_len);
    endtask

    task automatic rd_slow(input logic rew, input logic [7:0] exp_addr, input logic [7:0] exp_data);
        rd_req = 1'b1;
        rd_rewind = rew;
        tick();
        rd_rewind = 1'b0;
        check("rd_addr", ram_addr, exp_addr);
        check("rd_early", rd_valid | rd_done, 0);
        tick();
        tick();
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, exp_data);
        rd_req = 1'b0;
        tick();
        check("rd_valid_off", rd_valid, 0);
    endtask

    task automatic rd_fast_done();
        rd_req = 1'b1;
        tick();
        check("rd_done", rd_done, 1);
        check("rd_done_novalid", rd_valid, 0);
        rd_req = 1'b0;
        tick();
        check("rd_done_off", rd_done, 0);
    endtask

    initial begin
        int k;
        int m;
        int bad;
        int early;
        logic [7:0] ch;

        reset = 1'b0;
        clr_req = 1'b0;
        wr_req = 1'b0;
        wr_data = 8'h00;
        rd_req = 1'b0;
        rd_rewind = 1'b0;
        @(negedge sysclk);
        repeat (3) tick();

        // Reset values
        check("rst_clr_busy", clr_busy, 1);
        check("rst_ram_we", ram_we, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_wr_drop", wr_drop, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_len", len, 0);
        check("rst_full", full, 0);

        reset = 1'b1;
        sweep_check("boot");
        check("boot_we_off", ram_we, 0);

        // Append and backspace
        wr(8'h48, 1'b0, 8'd1);
        wr(8'h69, 1'b0, 8'd2);
        check("mem0_H", mem[0], 16'h8048);
        check("mem1_i", mem[1], 16'h8069);
        wr(8'h08, 1'b0, 8'd1);
        check("mem1_bksp", mem[1], 16'h0000);
        wr(8'h08, 1'b0, 8'd0);
        check("mem0_bksp", mem[0], 16'h0000);
        wr(8'h08, 1'b1, 8'd0);
        wr(8'h08, 1'b1, 8'd0);

        // Fill to the limit
        for (int i = 0; i < 160; i++) begin
            ch = 8'h30 + 8'(i % 64);
            wr_req = 1'b1;
            wr_data = ch;
            tick();
            wr_req = 1'b0;
            tick();
        end
        check("fill_len", len, 160);
        check("fill_full", full, 1);
        check("mem159", mem[159], 16'h804F);
        wr(8'h78, 1'b1, 8'd160);
        check("full_hold", full, 1);
        check("mem160_untouched", mem[160], 16'h0000);

        // Requested clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        sweep_check("clr");
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != 16'h0) bad++;
        check("clr_mem_zero", bad, 0);
        check("clr_full", full, 0);

        // Playback
        wr(8'h41, 1'b0, 8'd1);
        wr(8'h42, 1'b0, 8'd2);
        rd_rewind = 1'b1;
        tick();
        rd_rewind = 1'b0;
        rd_slow(1'b0, 8'd0, 8'h41);
        rd_slow(1'b0, 8'd1, 8'h42);
        rd_fast_done();

        // Backspace clamps the read pointer: ptr 2 -> 1, then 'C' lands at 1
        wr(8'h08, 1'b0, 8'd1);
        wr(8'h43, 1'b0, 8'd2);
        rd_slow(1'b0, 8'd1, 8'h43);
        rd_slow(1'b1, 8'd0, 8'h41);

        // Arbitration: clear, then write, then read
        clr_req = 1'b1;
        wr_req = 1'b1;
        wr_data = 8'h5A;
        rd_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("arb_clr_first", clr_busy, 1);
        k = 0;
        early = 0;
        while (!wr_ack && k < 400) begin
            if (rd_valid || rd_done) early++;
            k++;
            tick();
        end
        check("arb_wr_latency", k, 257);
        check("arb_no_early_rd", early, 0);
        wr_req = 1'b0;
        m = 0;
        while (!rd_valid && !rd_done && m < 20) begin
            m++;
            tick();
        end
        check("arb_rd_latency", m, 4);
        check("arb_rd_valid", rd_valid, 1);
        check("arb_rd_data", rd_data, 8'h5A);
        rd_req = 1'b0;
        check("arb_len", len, 1);

        // Reset in the middle of a sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (50) tick();
        check("mid_addr", ram_addr, 50);
        reset = 1'b0;
        #1;
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_busy", clr_busy, 1);
        check("mid_rst_len", len, 0);
        @(negedge sysclk);
        reset = 1'b1;
        sweep_check("rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
